cobra_run_ctrl: RTL and testbench
=================================

Name: cobra_run_ctrl

Overview:
Run/step/halt sequencer for the CYBERcobra core. It generates the core's synchronous reset and a per-cycle execute enable that gates PC update and register-file write inside the core. It halts execution on an operator command, a PC breakpoint, a jump-to-self instruction (end of program) or a cycle budget. It also exposes an executed-cycle counter for board display and debug.

Parameters:
RST_CYCLES, 2, cycles core_rst_o is held high after rst_i deasserts (legal range 1..255)
MAX_CYCLES, 0, executed-cycle budget before forced halt; 0 = unlimited

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle pulse: leave HALT and enter RUN
step_i  in  1  one-cycle pulse: leave HALT and execute exactly one instruction
halt_i  in  1  level: stop RUN
bp_en_i  in  1  breakpoint enable
bp_addr_i  in  32  breakpoint PC
pc_i  in  32  core program counter
instr_i  in  32  core current instruction (J = bit 31, offset = bits 12:5)
core_rst_o  out  1  synchronous reset to core
core_en_o  out  1  execute enable for this cycle
running_o  out  1  state == RUN
halted_o  out  1  state == HALT
halt_cause_o  out  2  0 manual, 1 breakpoint, 2 jump-to-self, 3 cycle limit
cycle_cnt_o  out  32  count of cycles with core_en_o = 1; saturates at 32'hFFFF_FFFF

Behaviour:
- States: RST_HOLD, HALT, RUN, STEP. Internal 8-bit hold counter; 1-bit skip flag.
- Reset (async): state RST_HOLD, hold counter 0, skip 0, core_rst_o 1, core_en_o 0, running_o 0, halted_o 0, halt_cause_o 0, cycle_cnt_o 0.
- RST_HOLD: core_rst_o = 1, core_en_o = 0. Hold counter increments each clock. Transition to HALT on the edge where the counter equals RST_CYCLES-1. core_rst_o is therefore high for exactly RST_CYCLES clocks after rst_i deasserts.
- HALT: core_en_o = 0.
  - step_i → STEP; step wins if start_i and step_i are high together.
  - start_i → RUN, and skip is set to 1.
  - halt_i is ignored in HALT.
- STEP: core_en_o = 1 unconditionally for one cycle. Breakpoint, self-loop and limit do not gate this cycle. Next state is HALT with halt_cause_o unchanged, unless the limit is hit (see below).
- RUN, combinational stop conditions:
  - hit_bp = bp_en_i & (pc_i == bp_addr_i) & ~skip
  - hit_self = instr_i[31] & (instr_i[12:5] == 0) & ~skip
  - stop = halt_i | hit_bp | hit_self
- RUN outputs: core_en_o = ~stop. skip clears after the first RUN cycle.
- RUN on stop: next state HALT, core does not execute that cycle. Cause priority: halt_i (0) > hit_bp (1) > hit_self (2).
- Resume skip: resuming at a breakpoint or self-loop PC executes one instruction before matching resumes.
- Cycle limit (MAX_CYCLES ≠ 0): when core_en_o = 1 and cycle_cnt_o + 1 == MAX_CYCLES, that cycle executes. Next state is HALT with cause 3, from RUN or STEP. In HALT with cycle_cnt_o ≥ MAX_CYCLES, start_i and step_i are ignored until rst_i.
- cycle_cnt_o increments on each clock with core_en_o = 1 and saturates. It is cleared only by rst_i.
- halt_cause_o updates only on entry to HALT from RUN, or on a limit halt.
- All registered outputs change on posedge clk_i. core_en_o is combinational from state, skip and inputs.
- rst_i asserted mid-RUN or mid-STEP: immediate return to reset values. The core sees core_rst_o = 1 asynchronously at the same time.

Test Plan:
- Reset release, RST_CYCLES = 2 → core_rst_o high for exactly 2 clocks, then halted_o = 1, core_en_o = 0, cycle_cnt_o = 0.
- step_i pulse ×3 from HALT → exactly 3 single-cycle core_en_o pulses, cycle_cnt_o = 3, halted_o = 1 after each.
- start_i with bp_en_i = 1, bp_addr_i = 0x10, core reaching pc_i = 0x10 → core_en_o = 0 in that cycle, halt_cause_o = 1. A second start_i executes at 0x10, core_en_o = 1 for one cycle, cycle_cnt_o increments.
- RUN, instr_i = 0x8000_0000 (J = 1, offset 0) → halt, halt_cause_o = 2. halt_i raised in the same cycle as a breakpoint match → halt_cause_o = 0.
- MAX_CYCLES = 5, start_i → exactly 5 enabled cycles, halt_cause_o = 3. Later start_i/step_i → core_en_o stays 0.
- rst_i asserted asynchronously mid-RUN → core_rst_o = 1 and cycle_cnt_o = 0 immediately (no clock edge). start_i and step_i pulsed together in HALT → STEP taken, one cycle only.

Source files
------------

// File: rtl/cobra_run_ctrl.sv
// Run/step/halt sequencer for the CYBERcobra core: holds the core in reset, then
// gates per-cycle execution on operator commands, breakpoints, self-loops and a cycle budget.
module cobra_run_ctrl #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        step_i,
    input  logic        halt_i,
    input  logic        bp_en_i,
    input  logic [31:0] bp_addr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        core_rst_o,
    output logic        core_en_o,
    output logic        running_o,
    output logic        halted_o,
    output logic [1:0]  halt_cause_o,
    output logic [31:0] cycle_cnt_o
);

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_HALT     = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } state_e;

    localparam logic [1:0]  CAUSE_MANUAL = 2'd0;
    localparam logic [1:0]  CAUSE_BP     = 2'd1;
    localparam logic [1:0]  CAUSE_SELF   = 2'd2;
    localparam logic [1:0]  CAUSE_LIMIT  = 2'd3;
    localparam logic [7:0]  HOLD_LAST    = 8'(RST_CYCLES - 32'd1);
    localparam logic [32:0] MAX_EXT      = 33'(MAX_CYCLES);
    localparam logic        LIMIT_ON     = (MAX_CYCLES != 32'd0);

    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        skip_q, skip_d;
    logic        core_rst_q, core_rst_d;
    logic        running_q, running_d;
    logic        halted_q, halted_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    logic        hit_bp_s;
    logic        hit_self_s;
    logic        stop_s;
    logic        core_en_s;
    logic [32:0] cnt_inc_s;
    logic        limit_hit_s;
    logic        limit_done_s;

    // Stop conditions, execute enable and cycle-budget comparisons.
    always_comb begin
        hit_bp_s   = bp_en_i & (pc_i == bp_addr_i) & ~skip_q;
        hit_self_s = instr_i[31] & (instr_i[12:5] == 8'd0) & ~skip_q;
        stop_s     = halt_i | hit_bp_s | hit_self_s;
        case (state_q)
            ST_RUN:  core_en_s = ~stop_s;
            ST_STEP: core_en_s = 1'b1;
            default: core_en_s = 1'b0;
        endcase
        cnt_inc_s    = {1'b0, cycle_cnt_q} + 33'd1;
        limit_hit_s  = LIMIT_ON & core_en_s & (cnt_inc_s == MAX_EXT);
        limit_done_s = LIMIT_ON & ({1'b0, cycle_cnt_q} >= MAX_EXT);
    end

    // Next-state, halt cause and registered-output decode.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        skip_d     = skip_q;
        cause_d    = cause_q;
        case (state_q)
            ST_RST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RST_HOLD;
                end
            end
            ST_HALT: begin
                // An exhausted budget locks the sequencer until the next reset.
                if (limit_done_s) begin
                    state_d = ST_HALT;
                end else if (step_i) begin
                    state_d = ST_STEP;
                end else if (start_i) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (stop_s) begin
                    state_d = ST_HALT;
                    if (halt_i) begin
                        cause_d = CAUSE_MANUAL;
                    end else if (hit_bp_s) begin
                        cause_d = CAUSE_BP;
                    end else begin
                        cause_d = CAUSE_SELF;
                    end
                end else if (limit_hit_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_LIMIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                if (limit_hit_s) begin
                    cause_d = CAUSE_LIMIT;
                end else begin
                    cause_d = cause_q;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase

        if (core_en_s && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end

        core_rst_d = (state_d == ST_RST_HOLD);
        running_d  = (state_d == ST_RUN);
        halted_d   = (state_d == ST_HALT);
    end

    // State and output registers; reset drives the core reset high immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RST_HOLD;
            hold_cnt_q  <= 8'd0;
            skip_q      <= 1'b0;
            core_rst_q  <= 1'b1;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            cause_q     <= 2'd0;
            cycle_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            skip_q      <= skip_d;
            core_rst_q  <= core_rst_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            cause_q     <= cause_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign core_en_o    = core_en_s;
    assign core_rst_o   = core_rst_q;
    assign running_o    = running_q;
    assign halted_o     = halted_q;
    assign halt_cause_o = cause_q;
    assign cycle_cnt_o  = cycle_cnt_q;

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Self-checking bench for cobra_run_ctrl: directed vector table, hand sequences for
// reset/limit corners, and randomized stimulus against a rule-level reference model.
module tb_cobra_run_ctrl;

    logic        clk;
    logic        rst, rst_lim;
    logic        start, step, halt, bp_en;
    logic [31:0] bp_addr, pc, instr;

    logic        core_rst_o, core_en_o, running_o, halted_o;
    logic [1:0]  halt_cause_o;
    logic [31:0] cycle_cnt_o;
    logic        l_core_rst, l_core_en, l_running, l_halted;
    logic [1:0]  l_cause;
    logic [31:0] l_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    cobra_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .step_i(step), .halt_i(halt),
        .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc), .instr_i(instr),
        .core_rst_o(core_rst_o), .core_en_o(core_en_o), .running_o(running_o),
        .halted_o(halted_o), .halt_cause_o(halt_cause_o), .cycle_cnt_o(cycle_cnt_o)
    );

    cobra_run_ctrl #(.RST_CYCLES(2), .MAX_CYCLES(5)) dut_lim (
        .clk_i(clk), .rst_i(rst_lim), .start_i(start), .step_i(step), .halt_i(halt),
        .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc), .instr_i(instr),
        .core_rst_o(l_core_rst), .core_en_o(l_core_en), .running_o(l_running),
        .halted_o(l_halted), .halt_cause_o(l_cause), .cycle_cnt_o(l_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        start = 1'b0; step = 1'b0; halt = 1'b0; bp_en = 1'b0;
        pc = 32'h0; instr = 32'h0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start, step, halt, bp_en;
        logic [31:0] pc, instr;
        logic        exp_en, exp_run, exp_halt;
        logic [1:0]  exp_cause;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic hl, input logic be,
                                input logic [31:0] p, input logic [31:0] ins,
                                input logic en, input logic run, input logic hlt,
                                input logic [1:0] c, input logic [31:0] n);
        vec_t v;
        v.start = st; v.step = sp; v.halt = hl; v.bp_en = be; v.pc = p; v.instr = ins;
        v.exp_en = en; v.exp_run = run; v.exp_halt = hlt; v.exp_cause = c; v.exp_cnt = n;
        return v;
    endfunction

    // ---------------- reference model ----------------
    localparam int M_RST = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;

    typedef struct {
        int              mode;
        int              rst_left;
        bit              fresh;
        int              cause;
        longint unsigned count;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode = M_RST; m.rst_left = 2; m.fresh = 1'b0; m.cause = 0; m.count = 0;
        return m;
    endfunction

    function automatic bit mdl_bp(mdl_t m);
        return bp_en && (pc == bp_addr) && !m.fresh;
    endfunction

    function automatic bit mdl_en(mdl_t m);
        bit self_loop;
        self_loop = instr[31] && (((instr >> 5) & 32'hFF) == 32'h0) && !m.fresh;
        if (m.mode == M_STEP) return 1'b1;
        if (m.mode == M_RUN)  return !(halt || mdl_bp(m) || self_loop);
        return 1'b0;
    endfunction

    function automatic mdl_t mdl_clock(mdl_t m, longint unsigned maxc);
        mdl_t n;
        bit en, lim;
        n   = m;
        en  = mdl_en(m);
        lim = (maxc != 0) && en && (m.count + 1 == maxc);
        if (en && m.count < 64'hFFFF_FFFF) n.count = m.count + 1;
        case (m.mode)
            M_RST: begin
                n.rst_left = m.rst_left - 1;
                if (n.rst_left == 0) n.mode = M_HALT;
            end
            M_HALT: begin
                if (!((maxc != 0) && (m.count >= maxc))) begin
                    if (step) n.mode = M_STEP;
                    else if (start) begin n.mode = M_RUN; n.fresh = 1'b1; end
                end
            end
            M_RUN: begin
                n.fresh = 1'b0;
                if (!en) begin
                    n.mode  = M_HALT;
                    n.cause = halt ? 0 : (mdl_bp(m) ? 1 : 2);
                end else if (lim) begin
                    n.mode  = M_HALT;
                    n.cause = 3;
                end
            end
            M_STEP: begin
                n.mode = M_HALT;
                if (lim) n.cause = 3;
            end
            default: n = m;
        endcase
        return n;
    endfunction

    task automatic cmp_model(input string tag, input mdl_t m, input logic crst, input logic en,
                             input logic run, input logic hlt, input logic [1:0] c,
                             input logic [31:0] n);
        check({tag, "_core_rst"}, 32'(crst), 32'(m.mode == M_RST));
        check({tag, "_core_en"},  32'(en),   32'(mdl_en(m)));
        check({tag, "_running"},  32'(run),  32'(m.mode == M_RUN));
        check({tag, "_halted"},   32'(hlt),  32'(m.mode == M_HALT));
        check({tag, "_cause"},    32'(c),    32'(m.cause));
        check({tag, "_cnt"},      n,         m.count[31:0]);
    endtask

    mdl_t m0, m1;
    int   n_clk;
    int   en_seen;

    initial begin
        rst = 1'b1; rst_lim = 1'b1;
        bp_addr = 32'h10;
        set_idle();

        // Reset values, applied asynchronously before any clock edge.
        #2;
        check("rst_core_rst", 32'(core_rst_o), 32'd1);
        check("rst_core_en",  32'(core_en_o),  32'd0);
        check("rst_running",  32'(running_o),  32'd0);
        check("rst_halted",   32'(halted_o),   32'd0);
        check("rst_cause",    32'(halt_cause_o), 32'd0);
        check("rst_cnt",      cycle_cnt_o,     32'd0);

        // Core reset must stay high for exactly RST_CYCLES clocks after release.
        @(negedge clk);
        rst = 1'b0;
        n_clk = 0;
        while (core_rst_o === 1'b1 && n_clk < 10) begin
            @(posedge clk); #1; n_clk++;
        end
        check("rst_hold_clocks", 32'(n_clk), 32'd2);
        check("post_rst_halted", 32'(halted_o), 32'd1);
        check("post_rst_en",     32'(core_en_o), 32'd0);
        check("post_rst_cnt",    cycle_cnt_o,    32'd0);
        @(negedge clk);

        // Directed vectors: step x3, breakpoint + resume, self-loop, priorities, start+step.
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b1,2'd0,32'd0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,2'd0,32'd0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b1,2'd0,32'd1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,2'd0,32'd1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b1,2'd0,32'd2));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,2'd0,32'd2));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b1,2'd0,32'd3));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,32'h0C,32'h0,        1'b0,1'b1,1'b0,2'd0,32'd3));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h0C,32'h0,        1'b1,1'b1,1'b0,2'd0,32'd4));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h10,32'h0,        1'b0,1'b0,1'b1,2'd1,32'd4));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,32'h10,32'h0,        1'b0,1'b1,1'b0,2'd1,32'd4));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h10,32'h0,        1'b1,1'b1,1'b0,2'd1,32'd5));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h14,32'h8000_0020,1'b1,1'b1,1'b0,2'd1,32'd6));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h14,32'h8000_0000,1'b0,1'b0,1'b1,2'd2,32'd6));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,32'h14,32'h8000_0000,1'b0,1'b1,1'b0,2'd2,32'd6));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h14,32'h8000_0000,1'b1,1'b1,1'b0,2'd2,32'd7));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,32'h10,32'h8000_0000,1'b0,1'b0,1'b1,2'd0,32'd7));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b1,2'd0,32'd7));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,32'h00,32'h0,        1'b0,1'b1,1'b0,2'd0,32'd7));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h20,32'h0,        1'b1,1'b1,1'b0,2'd0,32'd8));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,32'h10,32'h8000_0000,1'b0,1'b0,1'b1,2'd1,32'd8));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,2'd1,32'd8));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h00,32'h0,        1'b1,1'b0,1'b1,2'd1,32'd9));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b1,2'd1,32'd9));

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; step = vecs[i].step; halt = vecs[i].halt;
            bp_en = vecs[i].bp_en; pc = vecs[i].pc; instr = vecs[i].instr;
            #2;
            check($sformatf("vec%0d_en", i), 32'(core_en_o), 32'(vecs[i].exp_en));
            @(posedge clk); #1;
            check($sformatf("vec%0d_running", i), 32'(running_o), 32'(vecs[i].exp_run));
            check($sformatf("vec%0d_halted", i),  32'(halted_o),  32'(vecs[i].exp_halt));
            check($sformatf("vec%0d_cause", i),   32'(halt_cause_o), 32'(vecs[i].exp_cause));
            check($sformatf("vec%0d_cnt", i),     cycle_cnt_o,   vecs[i].exp_cnt);
            @(negedge clk);
        end
        set_idle();

        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid_run_running", 32'(running_o), 32'd1);
        check("mid_run_cnt",     cycle_cnt_o,    32'd12);
        rst = 1'b1;
        #1;
        check("async_core_rst", 32'(core_rst_o), 32'd1);
        check("async_cnt",      cycle_cnt_o,     32'd0);
        check("async_running",  32'(running_o),  32'd0);
        check("async_en",       32'(core_en_o),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_clk = 0;
        while (core_rst_o === 1'b1 && n_clk < 10) begin
            @(posedge clk); #1; n_clk++;
        end
        check("rerst_hold_clocks", 32'(n_clk), 32'd2);
        check("rerst_halted", 32'(halted_o), 32'd1);
        @(negedge clk);

        // Cycle budget of 5 on the limited instance.
        rst_lim = 1'b0;
        n_clk = 0;
        while (l_core_rst === 1'b1 && n_clk < 10) begin
            @(posedge clk); #1; n_clk++;
        end
        check("lim_hold_clocks", 32'(n_clk), 32'd2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        en_seen = 0;
        for (int k = 0; k < 12; k++) begin
            #2;
            if (l_core_en === 1'b1) en_seen++;
            @(negedge clk);
        end
        check("lim_enabled_cycles", 32'(en_seen), 32'd5);
        check("lim_cause",  32'(l_cause),  32'd3);
        check("lim_halted", 32'(l_halted), 32'd1);
        check("lim_cnt",    l_cnt,         32'd5);
        for (int k = 0; k < 4; k++) begin
            start = (k == 0) || (k == 2);
            step  = (k == 0) || (k == 1);
            #2;
            check($sformatf("lim_locked_en%0d", k), 32'(l_core_en), 32'd0);
            @(posedge clk); #1;
            check($sformatf("lim_locked_halted%0d", k), 32'(l_halted), 32'd1);
            @(negedge clk);
        end
        check("lim_locked_cnt", l_cnt, 32'd5);
        set_idle();

        // Randomized stimulus on both instances against the reference model.
        rst = 1'b1; rst_lim = 1'b1;
        m0 = mdl_reset(); m1 = mdl_reset();
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1; rst_lim = 1'b1;
            end else begin
                rst = 1'b0; rst_lim = 1'b0;
            end
            start = ($urandom_range(0, 3) == 0);
            step  = ($urandom_range(0, 5) == 0);
            halt  = ($urandom_range(0, 7) == 0);
            bp_en = ($urandom_range(0, 1) == 1);
            pc    = 32'h10 + 32'($urandom_range(0, 2)) * 32'd4;
            instr = $urandom();
            if ($urandom_range(0, 3) == 0) instr = (instr & 32'hFFFF_E01F) | 32'h8000_0000;
            if (rst) begin
                m0 = mdl_reset(); m1 = mdl_reset();
            end
            #2;
            cmp_model("rand_u", m0, core_rst_o, core_en_o, running_o, halted_o, halt_cause_o, cycle_cnt_o);
            cmp_model("rand_l", m1, l_core_rst, l_core_en, l_running, l_halted, l_cause, l_cnt);
            @(posedge clk);
            if (!rst) begin
                m0 = mdl_clock(m0, 0);
                m1 = mdl_clock(m1, 5);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
